// File: rtl/kan_result_serializer_pkg.sv
// kan_result_serializer_pkg
//   Shared definitions for the result serializer:
//   - state_t / COLLECT / EMIT : two-state FSM encoding
//   - idx_width()              : lane index width, never below 1 bit
//   The per-lane slot struct is declared in the top level, where its field
//   widths (DATA/ID/DEST/USER) are known, and handed to the hold slot as a
//   type parameter.
package kan_result_serializer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t COLLECT = 1'b0;
  localparam state_t EMIT    = 1'b1;

  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/kan_axis_hold_slot.sv
// kan_axis_hold_slot
//   Single-entry capture register with a full flag.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     load     : capture d and set full
//     clear    : drop full (data is kept, it is simply no longer valid)
//     d        : word plus sidebands to capture
//     full     : slot holds a word not yet emitted
//     q        : captured word plus sidebands
module kan_axis_hold_slot #(
  parameter type slot_t = logic
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  slot_t d,
  output logic  full,
  output slot_t q
);

  logic  full_reg;
  slot_t q_reg;

  // clear wins over load; the top never asserts both for one slot anyway
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg <= 1'b0;
      q_reg    <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      full_reg <= 1'b1;
      q_reg    <= d;
    end
  end

  assign full = full_reg;
  assign q    = q_reg;

endmodule

// File: rtl/kan_result_serializer.sv
// kan_result_serializer
//   Captures one word from each of CHANNELS AXI-Stream result lanes, then
//   replays the group lane 0 first on a single AXI-Stream master. Flags a
//   group whose tlast bits disagree across lanes.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     s_axis_rslt_*       : CHANNELS packed input lanes (lane i at slice i)
//     m_axis_*            : serialized output stream, tkeep all ones
//     err_tlast_mismatch  : one-cycle pulse on entering EMIT with mixed tlast
//     busy                : EMIT in progress or any lane slot holding a word
module kan_result_serializer
  import kan_result_serializer_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int IDX_W      = idx_width(CHANNELS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   s_axis_rslt_tdata,
  input  logic [CHANNELS-1:0]              s_axis_rslt_tvalid,
  output logic [CHANNELS-1:0]              s_axis_rslt_tready,
  input  logic [CHANNELS-1:0]              s_axis_rslt_tlast,
  input  logic [CHANNELS*ID_WIDTH-1:0]     s_axis_rslt_tid,
  input  logic [CHANNELS*DEST_WIDTH-1:0]   s_axis_rslt_tdest,
  input  logic [CHANNELS*USER_WIDTH-1:0]   s_axis_rslt_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             err_tlast_mismatch,
  output logic                             busy
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } slot_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             err_reg;

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] cap;
  logic [CHANNELS-1:0] slot_last;
  logic [CHANNELS-1:0] last_next;
  slot_t               slot_d [CHANNELS];
  slot_t               slot_q [CHANNELS];
  slot_t               sel;

  logic in_emit;
  logic m_fire;
  logic at_last_idx;
  logic clear_slots;
  logic go_emit;

  assign in_emit     = (state_reg == EMIT);
  assign m_fire      = in_emit & m_axis_tready;
  assign at_last_idx = (idx_reg == IDX_W'(CHANNELS - 1));
  assign clear_slots = m_fire & at_last_idx;

  // Input side only sees the state register and full flags, so m_tready
  // never reaches s_tready combinationally.
  assign s_axis_rslt_tready = in_emit ? '0 : ~full;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign cap[gi]    = s_axis_rslt_tvalid[gi] & s_axis_rslt_tready[gi];
      assign slot_d[gi] = '{data: s_axis_rslt_tdata[gi*DATA_WIDTH +: DATA_WIDTH],
                            last: s_axis_rslt_tlast[gi],
                            id:   s_axis_rslt_tid[gi*ID_WIDTH +: ID_WIDTH],
                            dest: s_axis_rslt_tdest[gi*DEST_WIDTH +: DEST_WIDTH],
                            user: s_axis_rslt_tuser[gi*USER_WIDTH +: USER_WIDTH]};

      kan_axis_hold_slot #(
        .slot_t (slot_t)
      ) u_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (cap[gi]),
        .clear (clear_slots),
        .d     (slot_d[gi]),
        .full  (full[gi]),
        .q     (slot_q[gi])
      );

      assign slot_last[gi] = slot_q[gi].last;
      // tlast as it will be held after this edge, so the mismatch check can
      // be registered on the same edge that captures the final lane
      assign last_next[gi] = cap[gi] ? s_axis_rslt_tlast[gi] : slot_last[gi];
    end
  endgenerate

  // Enter EMIT on the edge that fills the last empty slot, so m_tvalid rises
  // the cycle right after the final capture.
  assign go_emit = ~in_emit & (&(full | cap));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= COLLECT;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (!in_emit) begin
        if (go_emit) begin
          state_reg <= EMIT;
          idx_reg   <= '0;
          err_reg   <= ((|last_next) != (&last_next));
        end
      end else if (m_fire) begin
        if (at_last_idx) begin
          state_reg <= COLLECT;
          idx_reg   <= '0;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  // Output mux over registered slots
  always_comb begin
    sel = slot_q[0];
    for (int i = 1; i < CHANNELS; i++) begin
      if (idx_reg == IDX_W'(i)) sel = slot_q[i];
    end
  end

  assign m_axis_tvalid      = in_emit;
  assign m_axis_tdata       = sel.data;
  assign m_axis_tid         = sel.id;
  assign m_axis_tdest       = sel.dest;
  assign m_axis_tuser       = sel.user;
  assign m_axis_tkeep       = '1;
  // A misaligned group still emits, but end-of-packet only when every lane agrees
  assign m_axis_tlast       = in_emit & at_last_idx & (&slot_last);
  assign err_tlast_mismatch = err_reg;
  assign busy               = in_emit | (|full);

endmodule

// File: tb/tb_kan_result_serializer.sv
module tb_kan_result_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-lane instance
  logic [63:0] s_tdata  = '0;
  logic [3:0]  s_tvalid = '0;
  logic [3:0]  s_tready;
  logic [3:0]  s_tlast  = '0;
  logic [3:0]  s_tid    = '0;
  logic [3:0]  s_tdest  = '0;
  logic [3:0]  s_tuser  = '0;
  logic [15:0] m_tdata;
  logic [1:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        m_tid, m_tdest, m_tuser;
  logic        err;
  logic        busy;

  // 1-lane instance
  logic [15:0] s1_tdata  = '0;
  logic        s1_tvalid = 1'b0;
  logic        s1_tready;
  logic        s1_tlast  = 1'b0;
  logic        s1_tid    = 1'b0;
  logic        s1_tdest  = 1'b0;
  logic        s1_tuser  = 1'b0;
  logic [15:0] m1_tdata;
  logic [1:0]  m1_tkeep;
  logic        m1_tvalid;
  logic        m1_tready = 1'b0;
  logic        m1_tlast;
  logic        m1_tid, m1_tdest, m1_tuser;
  logic        err1;
  logic        busy1;

  kan_result_serializer #(.CHANNELS(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_rslt_tdata(s_tdata), .s_axis_rslt_tvalid(s_tvalid),
    .s_axis_rslt_tready(s_tready), .s_axis_rslt_tlast(s_tlast),
    .s_axis_rslt_tid(s_tid), .s_axis_rslt_tdest(s_tdest), .s_axis_rslt_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .err_tlast_mismatch(err), .busy(busy)
  );

  kan_result_serializer #(.CHANNELS(1), .DATA_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_rslt_tdata(s1_tdata), .s_axis_rslt_tvalid(s1_tvalid),
    .s_axis_rslt_tready(s1_tready), .s_axis_rslt_tlast(s1_tlast),
    .s_axis_rslt_tid(s1_tid), .s_axis_rslt_tdest(s1_tdest), .s_axis_rslt_tuser(s1_tuser),
    .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid),
    .m_axis_tready(m1_tready), .m_axis_tlast(m1_tlast), .m_axis_tid(m1_tid),
    .m_axis_tdest(m1_tdest), .m_axis_tuser(m1_tuser),
    .err_tlast_mismatch(err1), .busy(busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // lane i: data base+i, tid = i[0], tdest = i[1], tuser = ~i[0]
  task automatic set_lanes(input logic [15:0] base);
    for (int i = 0; i < 4; i++) begin
      s_tdata[i*16 +: 16] = base + 16'(i);
      s_tid[i]   = i[0];
      s_tdest[i] = i[1];
      s_tuser[i] = ~i[0];
    end
  endtask

  // All lanes presented in one cycle, m_tready held high, group drained.
  task automatic run_group(input logic [15:0] base, input logic [3:0] lasts);
    logic all_l, any_l;
    all_l = &lasts;
    any_l = |lasts;
    @(posedge clk); #1;
    set_lanes(base);
    s_tlast  = lasts;
    s_tvalid = 4'hF;
    m_tready = 1'b1;
    @(negedge clk);
    check_val("grp_valid_before_capture", m_tvalid, 0);
    check_val("grp_err_before_capture", err, 0);
    @(posedge clk); #1;
    s_tvalid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("grp_valid", m_tvalid, 1);
      check_val("grp_data", m_tdata, base + 16'(k));
      check_val("grp_tlast", m_tlast, (k == 3) && all_l);
      check_val("grp_tid", m_tid, k & 1);
      check_val("grp_tdest", m_tdest, (k >> 1) & 1);
      check_val("grp_s_tready", s_tready, 0);
      check_val("grp_err", err, (k == 0) && (any_l != all_l));
    end
    @(negedge clk);
    check_val("grp_valid_after", m_tvalid, 0);
    check_val("grp_busy_after", busy, 0);
    check_val("grp_s_tready_after", s_tready, 4'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_idx;

    // reset state
    @(negedge clk);
    check_val("rst_m_tvalid", m_tvalid, 0);
    check_val("rst_m_tlast", m_tlast, 0);
    check_val("rst_m_tdata", m_tdata, 0);
    check_val("rst_err", err, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_m_tkeep", m_tkeep, 2'b11);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_s_tready", s_tready, 4'hF);

    // same-cycle group, no tlast
    run_group(16'h0001, 4'b0000);

    // staggered arrival: lane 3 first, lane 0 last
    m_tready = 1'b1;
    for (int j = 3; j >= 0; j--) begin
      @(posedge clk); #1;
      s_tvalid = 4'b0001 << j;
      s_tdata[j*16 +: 16] = 16'h0010 + 16'(j);
      s_tid[j] = j[0];
      s_tlast  = '0;
      @(negedge clk);
      check_val("stag_no_output", m_tvalid, 0);
      check_val("stag_s_tready", s_tready, (32'd1 << (j + 1)) - 1);
    end
    @(posedge clk); #1;
    s_tvalid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("stag_valid", m_tvalid, 1);
      check_val("stag_data", m_tdata, 16'h0010 + 16'(k));
      check_val("stag_s_tready3", s_tready[3], 0);
    end
    @(negedge clk);
    check_val("stag_s_tready_after", s_tready, 4'hF);

    // all tlast, m_tready toggling
    @(posedge clk); #1;
    set_lanes(16'h0020);
    s_tlast  = 4'hF;
    s_tvalid = 4'hF;
    m_tready = 1'b0;
    @(posedge clk); #1;
    s_tvalid = '0;
    exp_idx = 0;
    for (int c = 0; c < 20 && exp_idx < 4; c++) begin
      @(negedge clk);
      check_val("tog_valid", m_tvalid, 1);
      check_val("tog_data", m_tdata, 16'h0020 + 16'(exp_idx));
      check_val("tog_tid", m_tid, exp_idx & 1);
      check_val("tog_tlast", m_tlast, exp_idx == 3);
      if (c == 0) check_val("tog_err", err, 0);
      if (m_tready) exp_idx++;
      @(posedge clk); #1;
      m_tready = ~m_tready;
    end
    check_val("tog_transfers", exp_idx, 4);
    @(negedge clk);
    check_val("tog_valid_after", m_tvalid, 0);

    // misaligned tlast on lane 2 only
    run_group(16'h0030, 4'b0100);

    // async reset while idx == 2
    @(posedge clk); #1;
    set_lanes(16'h0040);
    s_tlast  = '0;
    s_tvalid = 4'hF;
    m_tready = 1'b1;
    @(posedge clk); #1;
    s_tvalid = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("mid_rst_idx2_data", m_tdata, 16'h0042);
    #1 rst = 1'b1;
    #1 check_val("mid_rst_valid_drop", m_tvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_s_tready", s_tready, 4'hF);
    check_val("mid_rst_valid", m_tvalid, 0);
    run_group(16'h0050, 4'b0000);

    // single-lane instance: register slice behaviour
    m_tready = 1'b0;
    @(posedge clk); #1;
    s1_tvalid = 1'b1;
    s1_tdata  = 16'hA5A5;
    s1_tlast  = 1'b0;
    m1_tready = 1'b1;
    @(negedge clk);
    check_val("c1_ready0", s1_tready, 1);
    check_val("c1_valid_pre", m1_tvalid, 0);
    @(posedge clk); #1;
    s1_tdata = 16'h5A5A;
    s1_tlast = 1'b1;
    @(negedge clk);
    check_val("c1_valid_w0", m1_tvalid, 1);
    check_val("c1_data_w0", m1_tdata, 16'hA5A5);
    check_val("c1_last_w0", m1_tlast, 0);
    check_val("c1_ready_busy", s1_tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("c1_gap_valid", m1_tvalid, 0);
    check_val("c1_ready1", s1_tready, 1);
    @(posedge clk); #1;
    s1_tvalid = 1'b0;
    @(negedge clk);
    check_val("c1_valid_w1", m1_tvalid, 1);
    check_val("c1_data_w1", m1_tdata, 16'h5A5A);
    check_val("c1_last_w1", m1_tlast, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("c1_valid_end", m1_tvalid, 0);
    check_val("c1_busy_end", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
